video_in_ctrl_slave: RTL and testbench
======================================

// Module: video_in_ctrl_slave
// PURPOSE
//  Avalon-MM slave register file fronting the video-in accelerator inside video_in_subsystem.
//  Host/bench masters write arguments and a COMMAND, then poll STATUS or take IRQ.
//  Block runs an IDLE/RUN/DONE FSM, pulses accel start, latches result, counts run cycles.
// PARAMETERS
//  ADDR_W      16   word address width of slave port
//  DATA_W      32   data width of slave port and accel result
//  NUM_ARGS    2    argument registers forwarded to accelerator (1..4)
// PORTS
//  clk_clk          in   1       single clock domain
//  reset_reset_n    in   1       reset, asynchronous, active-low
//  avs_address      in   ADDR_W  word address
//  avs_chipselect   in   1       slave select; read/write ignored when 0
//  avs_write        in   1       write strobe, active-high
//  avs_read         in   1       read strobe, active-high
//  avs_writedata    in   DATA_W  write data
//  avs_readdata     out  DATA_W  read data, fixed read latency 1
//  accel_start      out  1       one-cycle start pulse to accelerator
//  accel_args       out  NUM_ARGS*DATA_W  ARG registers, ARG0 in LSBs
//  accel_done       in   1       accelerator completion, level or pulse
//  accel_result     in   DATA_W  valid in the cycle accel_done=1
//  irq              out  1       level interrupt = DONE state & IRQ_EN
// BEHAVIOUR
//  Reset: state=IDLE; all regs, avs_readdata, accel_start, accel_args, irq = 0.
//  Register map (word addr): 0 COMMAND (WO, reads 0); 1 STATUS (RO); 2 CTRL (RW);
//   3 RESULT (RO); 4 CYCLES (RO); 8..8+NUM_ARGS-1 ARGn (RW). Other addrs: read 0, write ignored.
//  COMMAND bits: [0] START, [1] CLEAR. STATUS: [0] busy(RUN), [1] done(DONE), [2] overrun.
//  CTRL: [0] IRQ_EN. Writes to RO regs ignored.
//  Access valid only when avs_chipselect=1. Read: avs_readdata registered on the edge after
//   avs_read; 0 in cycles with no read. Read+write same cycle: read returns pre-write value.
//  FSM:
//   IDLE: START=1 -> RUN; CYCLES<=0; accel_start=1 the following cycle only.
//   RUN: CYCLES +1 per cycle, saturates at all-ones; START write ignored, sets overrun.
//        accel_done=1 -> DONE; RESULT<=accel_result; CYCLES frozen.
//        accel_done and START write same cycle: done wins, overrun set.
//        CLEAR in RUN ignored (no abort).
//   DONE: irq=IRQ_EN. CLEAR=1 -> IDLE (RESULT, CYCLES kept, overrun cleared).
//         START=1 (with or without CLEAR) -> RUN directly, new start pulse, CYCLES<=0.
//  accel_done outside RUN ignored. ARGn writes during RUN take effect immediately.
//  Reset asserted mid-RUN: immediate return to reset values; no start pulse re-issued.
//  Start pulse width exactly 1 cycle regardless of how long avs_write stays high;
//   each accepted START is a distinct write cycle (write held high = one write per cycle).
// STRUCTURE
//  Package video_in_ctrl_pkg: register address localparams, COMMAND/STATUS/CTRL bit
//   indices, FSM state encoding (IDLE=0, RUN=1, DONE=2).
//  One sub-module: sat_counter (width DATA_W, clr, en, saturating) for CYCLES.
//  Everything else flat in this module.
// TESTING
//  Reset then read STATUS -> readdata 0x0 one cycle after read; irq=0, accel_start=0.
//  Write ARG0=0x1234, COMMAND=0x1; accel_done after 10 cycles with result 0xCAFE ->
//   one-cycle accel_start, STATUS=0x2, RESULT=0xCAFE, CYCLES=10, accel_args[31:0]=0x1234.
//  CTRL=0x1, run to DONE -> irq=1; write COMMAND=0x2 -> irq=0 next cycle, STATUS=0x0.
//  During RUN write COMMAND=0x1 coincident with accel_done -> DONE, overrun=1 (STATUS=0x6),
//   no second start pulse.
//  Hold avs_write=1 with COMMAND=0x1 for 3 cycles from IDLE -> exactly one start pulse,
//   overrun=1; read unmapped addr 0x0055 -> 0x0.
//  Assert reset_reset_n=0 mid-RUN -> all outputs 0 asynchronously; after release STATUS=0x0.

Source files
------------

// File: rtl/video_in_ctrl_pkg.sv
// Shared constants for the video-in control slave: register map, bit fields, FSM encoding.
package video_in_ctrl_pkg;

  // Word addresses of the register file
  localparam int unsigned RegCommand = 0;
  localparam int unsigned RegStatus  = 1;
  localparam int unsigned RegCtrl    = 2;
  localparam int unsigned RegResult  = 3;
  localparam int unsigned RegCycles  = 4;
  localparam int unsigned RegArgBase = 8;

  // COMMAND bits
  localparam int unsigned CmdStart = 0;
  localparam int unsigned CmdClear = 1;

  // STATUS bits
  localparam int unsigned StatusBusy    = 0;
  localparam int unsigned StatusDone    = 1;
  localparam int unsigned StatusOverrun = 2;

  // CTRL bits
  localparam int unsigned CtrlIrqEn = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/video_in_ctrl_slave_if.sv
// Avalon-MM slave bus bundle between a host master and the video-in control slave.
interface video_in_ctrl_slave_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write, read, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, read, writedata,
    output readdata
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear, else increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/video_in_ctrl_slave.sv
// Register file and IDLE/RUN/DONE sequencer fronting the video-in accelerator.
module video_in_ctrl_slave
  import video_in_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_ARGS = 2
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  video_in_ctrl_slave_if.slave       avs,
  output logic                       accel_start,
  output logic [NUM_ARGS*DATA_W-1:0] accel_args,
  input  logic                       accel_done,
  input  logic [DATA_W-1:0]          accel_result,
  output logic                       irq
);

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic              overrun_q, overrun_d;
  logic              irq_en_q;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] cycles;
  logic              cyc_clr, cyc_en;
  logic [DATA_W-1:0] args_q [NUM_ARGS];
  logic [NUM_ARGS-1:0] arg_we;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] readdata_q;

  logic wr, rd;
  logic sel_cmd, sel_status, sel_ctrl, sel_result, sel_cycles;
  logic start_req, clear_req;

  assign wr = avs.chipselect & avs.write;
  assign rd = avs.chipselect & avs.read;

  assign sel_cmd    = (avs.address == ADDR_W'(RegCommand));
  assign sel_status = (avs.address == ADDR_W'(RegStatus));
  assign sel_ctrl   = (avs.address == ADDR_W'(RegCtrl));
  assign sel_result = (avs.address == ADDR_W'(RegResult));
  assign sel_cycles = (avs.address == ADDR_W'(RegCycles));

  // Held write strobes count once per cycle, so each cycle is a separate command
  assign start_req = wr & sel_cmd & avs.writedata[CmdStart];
  assign clear_req = wr & sel_cmd & avs.writedata[CmdClear];

  // Per-argument write enables
  always_comb begin
    arg_we = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      arg_we[i] = wr && (avs.address == ADDR_W'(RegArgBase + i));
    end
  end

  // Sequencer next-state, start pulse, overrun and result capture
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    overrun_d = overrun_q;
    result_d  = result_q;
    cyc_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d   = StRun;
          start_d   = 1'b1;
          cyc_clr   = 1'b1;
          overrun_d = 1'b0;
        end
      end
      StRun: begin
        // No abort: CLEAR is ignored, a second START only flags overrun
        if (start_req) begin
          overrun_d = 1'b1;
        end
        if (accel_done) begin
          state_d  = StDone;
          result_d = accel_result;
        end
      end
      StDone: begin
        if (start_req) begin
          state_d   = StRun;
          start_d   = 1'b1;
          cyc_clr   = 1'b1;
          overrun_d = 1'b0;
        end else if (clear_req) begin
          state_d   = StIdle;
          overrun_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Counts every cycle spent in RUN, including the one where done is seen
  assign cyc_en = (state_q == StRun);

  // Sequencer and captured-value registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      overrun_q <= overrun_d;
      result_q  <= result_d;
    end
  end

  // Host-writable CTRL and ARG registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_en_q <= 1'b0;
      for (int i = 0; i < NUM_ARGS; i++) begin
        args_q[i] <= '0;
      end
    end else begin
      if (wr && sel_ctrl) begin
        irq_en_q <= avs.writedata[CtrlIrqEn];
      end
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (arg_we[i]) begin
          args_q[i] <= avs.writedata;
        end
      end
    end
  end

  sat_counter #(
    .Width (DATA_W)
  ) u_cycles (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .clr   (cyc_clr),
    .en    (cyc_en),
    .count (cycles)
  );

  // Read mux over pre-write register values
  always_comb begin
    rdata = '0;
    if (sel_status) begin
      rdata[StatusBusy]    = (state_q == StRun);
      rdata[StatusDone]    = (state_q == StDone);
      rdata[StatusOverrun] = overrun_q;
    end else if (sel_ctrl) begin
      rdata[CtrlIrqEn] = irq_en_q;
    end else if (sel_result) begin
      rdata = result_q;
    end else if (sel_cycles) begin
      rdata = cycles;
    end
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (avs.address == ADDR_W'(RegArgBase + i)) begin
        rdata = args_q[i];
      end
    end
  end

  // Registered read data, zero in cycles without a read
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= rd ? rdata : '0;
    end
  end

  // Pack argument registers, ARG0 in the LSBs
  always_comb begin
    accel_args = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      accel_args[i*DATA_W +: DATA_W] = args_q[i];
    end
  end

  assign avs.readdata = readdata_q;
  assign accel_start  = start_q;
  assign irq          = (state_q == StDone) & irq_en_q;

endmodule

// File: tb/tb_video_in_ctrl_slave.sv
// Directed bench for the video-in control slave: register access, run/done flow, overrun, reset.
module tb_video_in_ctrl_slave;

  localparam int unsigned AddrW   = 16;
  localparam int unsigned DataW   = 32;
  localparam int unsigned NumArgs = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     accel_start;
  logic [NumArgs*DataW-1:0] accel_args;
  logic                     accel_done;
  logic [DataW-1:0]         accel_result;
  logic                     irq;

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;

  video_in_ctrl_slave_if #(.ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  video_in_ctrl_slave #(
    .ADDR_W   (AddrW),
    .DATA_W   (DataW),
    .NUM_ARGS (NumArgs)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs           (bus),
    .accel_start   (accel_start),
    .accel_args    (accel_args),
    .accel_done    (accel_done),
    .accel_result  (accel_result),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each sampled-high cycle of accel_start is one pulse cycle
  always @(posedge clk) begin
    if (accel_start) pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
  endtask

  task automatic do_write(input logic [AddrW-1:0] addr, input logic [DataW-1:0] data);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus_idle();
  endtask

  task automatic do_read(input logic [AddrW-1:0] addr, input logic [DataW-1:0] exp,
                         input string tag);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    tick();
    bus_idle();
    check(tag, 64'(bus.readdata), 64'(exp));
  endtask

  initial begin
    bus_idle();
    accel_done   = 1'b0;
    accel_result = '0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_start", 64'(accel_start), 64'h0);
    check("rst_args", 64'(accel_args), 64'h0);
    check("rst_readdata", 64'(bus.readdata), 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    do_read(16'd1, 32'h0, "status_after_reset");

    // Basic run: ARG0, START, done in the 10th RUN cycle
    do_write(16'd8, 32'h1234);
    do_write(16'd0, 32'h1);
    check("start_pulse_hi", 64'(accel_start), 64'h1);
    check("args0", 64'(accel_args[31:0]), 64'h1234);
    tick();
    check("start_pulse_lo", 64'(accel_start), 64'h0);
    repeat (8) tick();
    accel_done   = 1'b1;
    accel_result = 32'hCAFE;
    tick();
    accel_done   = 1'b0;
    accel_result = '0;
    check("irq_disabled", 64'(irq), 64'h0);
    do_read(16'd1, 32'h2, "status_done");
    do_read(16'd3, 32'hCAFE, "result");
    do_read(16'd4, 32'd10, "cycles");
    do_read(16'd0, 32'h0, "command_reads_zero");
    check("one_pulse", 64'(pulses), 64'd1);

    // IRQ enable, then CLEAR back to IDLE
    do_write(16'd2, 32'h1);
    check("irq_set", 64'(irq), 64'h1);
    do_read(16'd2, 32'h1, "ctrl_rb");
    do_write(16'd0, 32'h2);
    check("irq_clear", 64'(irq), 64'h0);
    do_read(16'd1, 32'h0, "status_idle");
    do_read(16'd3, 32'hCAFE, "result_kept");
    do_read(16'd4, 32'd10, "cycles_kept");

    // START write coincident with accel_done: done wins, overrun flagged
    do_write(16'd0, 32'h1);
    tick();
    tick();
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 16'd0;
    bus.writedata  = 32'h1;
    accel_done     = 1'b1;
    accel_result   = 32'hBEEF;
    tick();
    bus_idle();
    accel_done   = 1'b0;
    accel_result = '0;
    tick();
    check("no_second_pulse", 64'(pulses), 64'd2);
    do_read(16'd1, 32'h6, "status_overrun");
    do_read(16'd3, 32'hBEEF, "result2");
    check("irq_done", 64'(irq), 64'h1);

    // Write held three cycles from IDLE: one pulse, then overrun
    do_write(16'd0, 32'h2);
    do_write(16'd2, 32'h0);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 16'd0;
    bus.writedata  = 32'h1;
    repeat (3) tick();
    bus_idle();
    tick();
    check("held_one_pulse", 64'(pulses), 64'd3);
    do_read(16'd1, 32'h5, "status_busy_overrun");
    do_read(16'h0055, 32'h0, "unmapped");

    // Access rules on ARG registers during RUN
    bus.write     = 1'b1;
    bus.address   = 16'd8;
    bus.writedata = 32'hFFFF;
    tick();
    bus_idle();
    check("no_cs_ignored", 64'(accel_args[31:0]), 64'h1234);
    do_write(16'd9, 32'hA5A5);
    check("args1", 64'(accel_args[63:32]), 64'hA5A5);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 16'd8;
    bus.writedata  = 32'h5678;
    tick();
    bus_idle();
    check("rw_pre_value", 64'(bus.readdata), 64'h1234);
    check("rw_new_arg", 64'(accel_args[31:0]), 64'h5678);

    // Asynchronous reset mid-RUN while readdata is non-zero
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 16'd8;
    tick();
    bus_idle();
    check("pre_reset_read", 64'(bus.readdata), 64'h5678);
    rst_n = 1'b0;
    #1;
    check("areset_readdata", 64'(bus.readdata), 64'h0);
    check("areset_args", 64'(accel_args), 64'h0);
    check("areset_irq", 64'(irq), 64'h0);
    check("areset_start", 64'(accel_start), 64'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_pulse_after_reset", 64'(pulses), 64'd3);
    do_read(16'd1, 32'h0, "status_post_reset");
    do_read(16'd4, 32'h0, "cycles_post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
